// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the signals between the UART receive buffer and its neighbours:
// the byte strobe from the receiver, the host read handshake, occupancy and
// overflow status.
//
// Signals:
//   P_DATA      receiver -> fifo   received byte
//   data_valid  receiver -> fifo   one-cycle strobe, P_DATA valid
//   rd_en       host     -> fifo   read request
//   ovf_clr     host     -> fifo   clears the sticky overflow flag
//   rd_data     fifo     -> host   registered read data
//   rd_valid    fifo     -> host   one-cycle pulse, rd_data updated
//   empty/full  fifo     -> host   occupancy decode
//   count       fifo     -> host   occupancy 0..2^DEPTH_LOG2
//   ovf_flag    fifo     -> host   sticky overflow indicator
//   rx_byte_cnt, drop_cnt          statistics, only with UART_RX_FIFO_STATS_EN
//
// Modports: master = receiver/host side, slave = the fifo.
// Optional feature macro: UART_RX_FIFO_STATS_EN
// -----------------------------------------------------------------------------
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 3
) ();

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  rd_en;
  logic                  ovf_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovf_flag;

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0]           rx_byte_cnt;
  logic [7:0]            drop_cnt;

  modport master (
    output P_DATA, data_valid, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, ovf_flag,
    input  rx_byte_cnt, drop_cnt
  );

  modport slave (
    input  P_DATA, data_valid, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, ovf_flag,
    output rx_byte_cnt, drop_cnt
  );
`else
  modport master (
    output P_DATA, data_valid, rd_en, ovf_clr,
    input  rd_data, rd_valid, empty, full, count, ovf_flag
  );

  modport slave (
    input  P_DATA, data_valid, rd_en, ovf_clr,
    output rd_data, rd_valid, empty, full, count, ovf_flag
  );
`endif

endinterface : uart_rx_fifo_if

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer placed directly behind the UART receiver. Every data_valid
// strobe pushes P_DATA into a circular buffer of 2^DEPTH_LOG2 entries; the
// host drains it with rd_en and receives the byte one cycle later on
// rd_data/rd_valid. A byte arriving while the buffer is full (and no read
// frees a slot in the same cycle) is dropped and sets the sticky ovf_flag.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous reset, active low; discards all contents
//   bus   uart_rx_fifo_if.slave (see interface header for the signal list)
//
// Optional feature macro: UART_RX_FIFO_STATS_EN
//   adds rx_byte_cnt (accepted writes) and drop_cnt (overflow drops), both
//   wrapping and cleared by ovf_clr.
//
// All outputs come straight from flops; no input reaches an output without
// passing through a register.
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic           CLK,
  input  logic           RST,
  uart_rx_fifo_if.slave  bus
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ZERO  = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  // storage and state
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  empty_r;
  logic                  full_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic                  ovf_flag_r;

  // decoded handshakes
  logic                  wr_accept_s;
  logic                  rd_accept_s;
  logic                  ovf_s;
  logic [DEPTH_LOG2:0]   count_nxt_s;

  // Accept decisions; a read in the same cycle frees a slot for a write when
  // full, but an empty buffer never forwards the incoming byte to the reader.
  always_comb begin
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    ovf_s       = 1'b0;
    if (RST) begin
      wr_accept_s = bus.data_valid & (~full_r | bus.rd_en);
      rd_accept_s = bus.rd_en & ~empty_r;
      ovf_s       = bus.data_valid & full_r & ~bus.rd_en;
    end else begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
      ovf_s       = 1'b0;
    end
  end

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_accept_s, rd_accept_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage write; the array itself is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= bus.P_DATA;
    end
  end

  // Pointers, occupancy and its registered empty/full decode.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= CNT_ZERO;
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == CNT_ZERO);
      full_r  <= (count_nxt_s == CNT_FULL);
    end
  end

  // Registered read port; rd_data holds its value between reads.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  // Sticky overflow flag; a new overflow takes priority over a clear.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      ovf_flag_r <= 1'b0;
    end else if (ovf_s) begin
      ovf_flag_r <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_flag_r <= 1'b0;
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.count    = count_r;
  assign bus.ovf_flag = ovf_flag_r;

`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0] rx_byte_cnt_r;
  logic [7:0]  drop_cnt_r;

  // Statistics counters; ovf_clr restarts them, counting the current event.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_byte_cnt_r <= 16'h0000;
      drop_cnt_r    <= 8'h00;
    end else if (bus.ovf_clr) begin
      rx_byte_cnt_r <= {15'b0, wr_accept_s};
      drop_cnt_r    <= {7'b0, ovf_s};
    end else begin
      rx_byte_cnt_r <= rx_byte_cnt_r + {15'b0, wr_accept_s};
      drop_cnt_r    <= drop_cnt_r + {7'b0, ovf_s};
    end
  end

  assign bus.rx_byte_cnt = rx_byte_cnt_r;
  assign bus.drop_cnt    = drop_cnt_r;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Drives directed and random traffic into uart_rx_fifo. A queue-based model
// tracks the buffer contents; every accepted read pushes the expected byte
// into a scoreboard queue that an independent monitor pops whenever the DUT
// raises rd_valid. Status outputs are compared against the model each cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DL2   = 3;
  localparam int DEPTH = 1 << DL2;

  logic CLK;
  logic RST;

  uart_rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) bus ();

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // reference model state
  logic [7:0]  m_q[$];
  logic [7:0]  exp_q[$];
  logic        m_rdv;
  logic [7:0]  m_last;
  logic        m_flag;
  logic [15:0] m_rx;
  logic [7:0]  m_drop;
  bit          mon_en;

  int total;
  int bad;

  function automatic void chk(string nm, int unsigned act, int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    exp_q.delete();
    m_rdv  = 1'b0;
    m_last = 8'h00;
    m_flag = 1'b0;
    m_rx   = 16'h0000;
    m_drop = 8'h00;
  endfunction

  // Applies the buffer rules to one cycle of inputs.
  function automatic void model_step(logic rst, logic dv, logic [7:0] d, logic rd, logic clr);
    int sz;
    bit rd_acc;
    bit wr_acc;
    bit ovf;
    if (!rst) begin
      model_reset();
    end else begin
      sz     = m_q.size();
      rd_acc = rd && (sz > 0);
      wr_acc = dv && ((sz < DEPTH) || rd);
      ovf    = dv && (sz == DEPTH) && !rd;
      m_rdv  = rd_acc;
      if (rd_acc) begin
        m_last = m_q.pop_front();
        exp_q.push_back(m_last);
      end
      if (wr_acc) m_q.push_back(d);
      if (ovf) m_flag = 1'b1;
      else if (clr) m_flag = 1'b0;
      if (clr) begin
        m_rx   = wr_acc ? 16'h0001 : 16'h0000;
        m_drop = ovf ? 8'h01 : 8'h00;
      end else begin
        m_rx   = m_rx + (wr_acc ? 16'h0001 : 16'h0000);
        m_drop = m_drop + (ovf ? 8'h01 : 8'h00);
      end
    end
  endfunction

  task automatic step(input logic rst, input logic dv, input logic [7:0] d,
                      input logic rd, input logic clr);
    @(negedge CLK);
    RST            = rst;
    bus.data_valid = dv;
    bus.P_DATA     = d;
    bus.rd_en      = rd;
    bus.ovf_clr    = clr;
    model_step(rst, dv, d, rd, clr);
  endtask

  task automatic wr(input logic [7:0] d);
    step(1'b1, 1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge CLK) begin
    #1;
    if (mon_en) begin
      chk("rd_valid", bus.rd_valid, m_rdv);
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          chk("rd_data_sb", bus.rd_data, exp_q.pop_front());
        end
      end
      chk("rd_data_hold", bus.rd_data, m_last);
      chk("count", bus.count, m_q.size());
      chk("empty", bus.empty, (m_q.size() == 0) ? 1 : 0);
      chk("full", bus.full, (m_q.size() == DEPTH) ? 1 : 0);
      chk("ovf_flag", bus.ovf_flag, m_flag);
`ifdef UART_RX_FIFO_STATS_EN
      chk("rx_byte_cnt", bus.rx_byte_cnt, m_rx);
      chk("drop_cnt", bus.drop_cnt, m_drop);
`endif
    end
  end

  initial begin
    int ph;
    logic dv;
    logic rd;
    total = 0;
    bad   = 0;
    RST            = 1'b0;
    bus.data_valid = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.rd_en      = 1'b0;
    bus.ovf_clr    = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // reset then idle
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    idle(3);

    // single byte
    wr(8'hA5);
    rd_n(1);
    idle(2);

    // fill, partial drain, wrap, full drain
    for (int i = 1; i <= 8; i++) wr(8'(i));
    rd_n(3);
    for (int i = 9; i <= 11; i++) wr(8'(i));
    rd_n(8);
    idle(2);

    // overflow, clear racing overflow, lone clear
    for (int i = 0; i < 8; i++) wr(8'h20 + 8'(i));
    wr(8'hEE);
    step(1'b1, 1'b1, 8'hEF, 1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // simultaneous read/write at full, then drain
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    rd_n(8);
    idle(2);

    // simultaneous read/write at empty: write only, no bypass
    step(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    idle(1);
    rd_n(2);
    idle(1);

    // reset mid-stream with five entries held
    for (int i = 0; i < 5; i++) wr(8'h70 + 8'(i));
    step(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
    wr(8'h3C);
    rd_n(1);
    idle(2);

    // randomized traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      ph = (i / 200) % 3;
      case (ph)
        0:       begin dv = ($urandom_range(0, 9) < 8); rd = ($urandom_range(0, 9) < 2); end
        1:       begin dv = ($urandom_range(0, 9) < 2); rd = ($urandom_range(0, 9) < 8); end
        default: begin dv = $urandom_range(0, 1) == 1; rd = $urandom_range(0, 1) == 1; end
      endcase
      step(($urandom_range(0, 399) != 0), dv, 8'($urandom_range(0, 255)), rd,
           ($urandom_range(0, 29) == 0));
    end

    idle(4);
    @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo
